updown_mod_counter: RTL and testbench

- Parametrised successor to the team's fixed 8-bit enable counter: up/down counting, parallel load, programmable modulus, wrap or saturate, one-shot or periodic run control, registered terminal-count pulse.
- Sits in the PMIC timing path as the generic event/delay counter feeding soft-start, dead-time and fault-timeout sequencers.

---
 rtl/udc_pkg.sv | 10 +
 rtl/udc_prescaler.sv | 21 ++
 rtl/updown_mod_counter.sv | 80 ++++++++
 tb/tb_updown_mod_counter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/udc_pkg.sv
// udc_pkg: state, direction and mode encodings shared by updown_mod_counter
package udc_pkg;
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_HALT = 2'b10;
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;
endpackage

// File: rtl/udc_prescaler.sv
// udc_prescaler: divide-by-(prescale+1) strobe for updown_mod_counter, built only with UDC_PRESCALE_EN
`ifdef UDC_PRESCALE_EN
module udc_prescaler #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         tick,
    input  logic [W-1:0] prescale,
    output logic         strobe
);
    logic [W-1:0] cnt;
    // >= keeps the divider from running away if prescale drops below cnt
    assign strobe = tick && !clear && cnt >= prescale;
    always_ff @(posedge clk) begin
        if (reset || clear) cnt <= '0;
        else if (tick) cnt <= strobe ? '0 : cnt + 1'b1;
    end
endmodule
`endif

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: up/down modulo counter with load, wrap/saturate, one-shot run control and tc pulse.
// Define UDC_PRESCALE_EN to add the prescale input and internal step prescaler.
module updown_mod_counter
    import udc_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 2**WIDTH-1,
    parameter int SATURATE = MODE_WRAP
`ifdef UDC_PRESCALE_EN
    ,
    parameter int PRESCALE_W = 4
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             start,
    input  logic             stop,
    input  logic             one_shot,
`ifdef UDC_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale,
`endif
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             running,
    output logic             halted
);
    localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX_VAL);
    localparam logic SAT = SATURATE == MODE_SAT;

    logic [1:0]       state;
    logic             os;
    logic             cnt_en;
    logic             step;
    logic             term;
    logic             halt_now;
    logic [WIDTH-1:0] nxt;

    // load, stop and start all outrank counting in the same cycle
    assign cnt_en = state == ST_RUN && enable && !load && !stop && !start;

`ifdef UDC_PRESCALE_EN
    udc_prescaler #(.W(PRESCALE_W)) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .clear    (load || start || stop),
        .tick     (cnt_en),
        .prescale (prescale),
        .strobe   (step)
    );
`else
    assign step = cnt_en;
`endif

    // out above TOP can only come from a misconfigured MAX_VAL; treat it as terminal
    assign term = up_dn == DIR_UP ? out >= TOP : (out == '0 || out > TOP);
    assign nxt = term ? (SAT ? out : (up_dn == DIR_UP ? '0 : TOP))
                      : (up_dn == DIR_UP ? out + 1'b1 : out - 1'b1);
    assign halt_now = step && term && (SAT || os);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            os    <= 1'b0;
            out   <= '0;
            tc    <= 1'b0;
        end else begin
            state <= stop ? ST_IDLE : start ? ST_RUN : halt_now ? ST_HALT : state;
            if (start && !stop) os <= one_shot;
            out <= load ? (data > TOP ? TOP : data) : step ? nxt : out;
            tc  <= step && term;
        end
    end

    assign running = state == ST_RUN;
    assign halted  = state == ST_HALT;
endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: randomized and directed checks of wrap and saturate counters against a modulo-arithmetic model
module tb_updown_mod_counter;
    localparam int MAX = 9;

    logic       clk = 0;
    logic       reset = 1, enable = 0, up_dn = 1, load = 0, start = 0, stop = 0, one_shot = 0;
    logic [7:0] data = 0;
    logic [3:0] prescale = 0;
    logic [7:0] out_w, out_s;
    logic       tc_w, tc_s, run_w, run_s, halt_w, halt_s;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int out;
        bit run;
        bit halt;
        bit os;
        bit tc;
        int pc;
    } mdl_t;

    mdl_t mw, ms;

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(8), .MAX_VAL(MAX), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load), .data(data),
        .start(start), .stop(stop), .one_shot(one_shot),
`ifdef UDC_PRESCALE_EN
        .prescale(prescale),
`endif
        .out(out_w), .tc(tc_w), .running(run_w), .halted(halt_w)
    );

    updown_mod_counter #(.WIDTH(8), .MAX_VAL(MAX), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load), .data(data),
        .start(start), .stop(stop), .one_shot(one_shot),
`ifdef UDC_PRESCALE_EN
        .prescale(prescale),
`endif
        .out(out_s), .tc(tc_s), .running(run_s), .halted(halt_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic mdl_t advance(mdl_t m, bit sat);
        mdl_t n = m;
        bit fire, term;
        int nxt;
        if (reset) begin
            n = '{out: 0, run: 0, halt: 0, os: 0, tc: 0, pc: 0};
            return n;
        end
        n.tc = 0;
        fire = m.run && enable && !load && !stop && !start;
`ifdef UDC_PRESCALE_EN
        if (load || stop || start) n.pc = 0;
        else if (fire) begin
            if (m.pc >= int'(prescale)) n.pc = 0;
            else begin
                n.pc = m.pc + 1;
                fire = 0;
            end
        end
`endif
        if (load) n.out = int'(data) > MAX ? MAX : int'(data);
        else if (fire) begin
            term = up_dn ? m.out == MAX : m.out == 0;
            nxt  = up_dn ? (m.out + 1) % (MAX + 1) : (m.out + MAX) % (MAX + 1);
            n.out = (term && sat) ? m.out : nxt;
            n.tc  = term;
            if (term && (sat || m.os)) begin
                n.run  = 0;
                n.halt = 1;
            end
        end
        if (stop) begin
            n.run  = 0;
            n.halt = 0;
        end else if (start) begin
            n.run  = 1;
            n.halt = 0;
            n.os   = one_shot;
        end
        return n;
    endfunction

    task automatic cycle();
        @(posedge clk);
        mw = advance(mw, 0);
        ms = advance(ms, 1);
        #1;
        check("w_out", out_w, mw.out);
        check("w_tc", tc_w, mw.tc);
        check("w_running", run_w, mw.run);
        check("w_halted", halt_w, mw.halt);
        check("s_out", out_s, ms.out);
        check("s_tc", tc_s, ms.tc);
        check("s_running", run_s, ms.run);
        check("s_halted", halt_s, ms.halt);
    endtask

    task automatic quiet();
        reset = 0; load = 0; start = 0; stop = 0; enable = 0;
    endtask

    initial begin
        int t1[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        int t2[5]  = '{2, 1, 0, 9, 8};
        mw = '{out: 0, run: 0, halt: 0, os: 0, tc: 0, pc: 0};
        ms = mw;
        reset = 1;
        cycle();
        cycle();
        check("rst_out", out_w, 0);
        check("rst_tc", tc_w, 0);
        check("rst_running", run_w, 0);
        check("rst_halted", halt_w, 0);

        quiet(); start = 1; up_dn = 1;
        cycle();
        quiet(); enable = 1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            check("t1_out", out_w, t1[i]);
            check("t1_tc", tc_w, t1[i] == 0);
            check("t1_running", run_w, 1);
        end

        quiet(); load = 1; stop = 1; data = 3;
        cycle();
        quiet(); start = 1; up_dn = 0; enable = 1;
        cycle();
        quiet(); enable = 1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t2_out", out_w, t2[i]);
            check("t2_tc", tc_w, t2[i] == 9);
        end
        quiet(); load = 1; data = 200;
        cycle();
        check("t2_clamp", out_w, 9);

        quiet(); load = 1; stop = 1; data = 7;
        cycle();
        quiet(); start = 1; up_dn = 1; one_shot = 0;
        cycle();
        quiet(); enable = 1;
        cycle();
        check("t3_out8", out_s, 8);
        cycle();
        check("t3_out9", out_s, 9);
        check("t3_tc_pre", tc_s, 0);
        cycle();
        check("t3_hold", out_s, 9);
        check("t3_tc", tc_s, 1);
        check("t3_halted", halt_s, 1);
        check("t3_running", run_s, 0);
        cycle();
        check("t3_tc_once", tc_s, 0);
        check("t3_still9", out_s, 9);
        quiet(); start = 1;
        cycle();
        check("t3_rerun", run_s, 1);
        quiet(); enable = 1;
        cycle();
        check("t3_rehold", out_s, 9);
        check("t3_rehalt", halt_s, 1);

        quiet(); load = 1; stop = 1; data = 1;
        cycle();
        quiet(); start = 1; one_shot = 1; up_dn = 0;
        cycle();
        quiet(); one_shot = 0; enable = 1;
        cycle();
        check("t4_out0", out_w, 0);
        cycle();
        check("t4_out9", out_w, 9);
        check("t4_tc", tc_w, 1);
        check("t4_halted", halt_w, 1);
        for (int i = 0; i < 3; i++) begin
            enable = i[0];
            cycle();
            check("t4_hold", out_w, 9);
            check("t4_tc_off", tc_w, 0);
        end

        quiet(); start = 1; up_dn = 1;
        cycle();
        quiet(); enable = 1;
        cycle();
        cycle();
        quiet(); load = 1; stop = 1; enable = 1; data = 5;
        cycle();
        check("t5_out", out_w, 5);
        check("t5_idle", run_w | halt_w, 0);
        check("t5_tc", tc_w, 0);
        quiet(); start = 1;
        cycle();
        quiet(); enable = 1;
        cycle();
        quiet(); reset = 1; enable = 1;
        cycle();
        check("t5_rst_out", out_w, 0);
        check("t5_rst_running", run_w, 0);
        check("t5_rst_tc", tc_w, 0);

`ifdef UDC_PRESCALE_EN
        quiet(); prescale = 2; start = 1; up_dn = 1;
        cycle();
        quiet(); enable = 1;
        for (int i = 1; i <= 7; i++) begin
            cycle();
            check("ps_out", out_w, i / 3);
        end
        quiet(); load = 1; data = 0; enable = 1;
        cycle();
        quiet(); enable = 1;
        for (int i = 1; i <= 4; i++) begin
            cycle();
            check("ps_reload", out_w, i / 3);
        end
`endif

        for (int i = 0; i < 2000; i++) begin
            reset    = $urandom_range(0, 99) == 0;
            load     = $urandom_range(0, 19) == 0;
            stop     = $urandom_range(0, 29) == 0;
            start    = $urandom_range(0, 14) == 0;
            enable   = $urandom_range(0, 9) < 8;
            up_dn    = 1'($urandom);
            one_shot = 1'($urandom);
            data     = $urandom_range(0, 1) ? 8'($urandom_range(0, 12)) : 8'($urandom);
`ifdef UDC_PRESCALE_EN
            prescale = 4'($urandom_range(0, 3));
`endif
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
